// File: rtl/ssd_scroll_controller.sv
// ---------------------------------------------------------------------------
// ssd_scroll_controller
//
// Message sequencer for a six-digit seven-segment display bank. A producer
// loads a message of raw active-low segment glyphs over a valid/ready port.
// The message is then scrolled right-to-left across the six displays, one
// step every TICK_DIV clock cycles, with six blank positions between
// repetitions.
//
// Parameters:
//   MSG_MAX   message buffer depth in glyphs (>= 1)
//   TICK_DIV  clock cycles per scroll step (>= 2)
//
// Ports:
//   clk_i               main clock
//   rst_ni              asynchronous active-low reset
//   load_start_i        pulse: clear the buffer and start loading
//   ch_valid_i          glyph on ch_seg_i is valid
//   ch_seg_i            glyph, active-low, bit 0 = segment a .. bit 6 = segment g
//   ch_ready_o          glyph is accepted when ch_valid_i & ch_ready_o
//   load_done_i         pulse: end of message
//   msg_len_o           number of stored glyphs
//   busy_o              controller is loading or running
//   wrap_o              one-cycle pulse when the scroll offset returns to 0
//   display0_output_o .. display5_output_o
//                       segment outputs, display0 is the leftmost digit
//
// Optional feature (compile-time macro SSD_SCROLL_STATIC_EN):
//   When defined, a message of six glyphs or fewer is shown left-justified
//   and held still instead of scrolling. Longer messages scroll as usual.
// ---------------------------------------------------------------------------
module ssd_scroll_controller #(
  parameter int MSG_MAX  = 16,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         load_start_i,
  input  logic                         ch_valid_i,
  input  logic [0:6]                   ch_seg_i,
  output logic                         ch_ready_o,
  input  logic                         load_done_i,
  output logic [$clog2(MSG_MAX+1)-1:0] msg_len_o,
  output logic                         busy_o,
  output logic                         wrap_o,
  output logic [0:6]                   display0_output_o,
  output logic [0:6]                   display1_output_o,
  output logic [0:6]                   display2_output_o,
  output logic [0:6]                   display3_output_o,
  output logic [0:6]                   display4_output_o,
  output logic [0:6]                   display5_output_o
);

  localparam int LEN_W  = $clog2(MSG_MAX + 1);
  localparam int OFS_W  = $clog2(MSG_MAX + 6);
  // One extra bit so offset + digit position cannot overflow before the
  // modulo subtraction.
  localparam int IDX_W  = OFS_W + 1;
  localparam int TICK_W = $clog2(TICK_DIV);

  localparam logic [0:6]        BLANK     = 7'b1111111;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(MSG_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [OFS_W-1:0]  offset_q, offset_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              wrap_q, wrap_d;
  logic              ch_ready_q, ch_ready_d;
  logic [0:6]        buf_q  [MSG_MAX];
  logic [0:6]        disp_q [6];
  logic [0:6]        disp_d [6];

  logic              accept;
  logic              wr_en;
  logic              hold;
  logic [OFS_W-1:0]  last_ofs;
  logic [IDX_W-1:0]  period;
  logic [IDX_W-1:0]  idx;

  // The virtual sequence is the message followed by six blanks, so its
  // period is L+6 and the last valid offset is L+5.
  assign last_ofs = OFS_W'(len_q) + OFS_W'(5);
  assign period   = IDX_W'(len_q) + IDX_W'(6);

  // Short messages may be held still instead of scrolling.
`ifdef SSD_SCROLL_STATIC_EN
  assign hold = (32'(len_q) <= 32'd6);
`else
  assign hold = 1'b0;
`endif

  assign accept = (state_q == ST_LOAD) && ch_ready_q && ch_valid_i;

  // Next-state logic. load_start always wins: it clears the length and
  // discards any glyph offered in the same cycle. A glyph accepted in the
  // same cycle as load_done is stored before the empty-message test.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    offset_d = offset_q;
    tick_d   = tick_q;
    wrap_d   = 1'b0;
    wr_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          state_d = ST_LOAD;
          len_d   = '0;
        end
      end

      ST_LOAD: begin
        if (load_start_i) begin
          len_d = '0;
        end else begin
          if (accept) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_W'(1);
          end
          if (load_done_i) begin
            if (len_d == '0) begin
              state_d = ST_IDLE;
            end else begin
              state_d  = ST_RUN;
              offset_d = '0;
              tick_d   = '0;
            end
          end
        end
      end

      ST_RUN: begin
        if (load_start_i) begin
          state_d  = ST_LOAD;
          len_d    = '0;
          offset_d = '0;
          tick_d   = '0;
        end else if (!hold) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (offset_q == last_ofs) begin
              offset_d = '0;
              wrap_d   = 1'b1;
            end else begin
              offset_d = offset_q + OFS_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // ch_ready is registered, so it is computed from the state and length
    // that will be in effect after this edge.
    ch_ready_d = (state_d == ST_LOAD) && (len_d < LEN_FULL);
  end

  // Frame generation from the current offset. Display k shows position
  // (offset + k) mod P; because offset < P and k < 6 < P, a single
  // compare-and-subtract is enough. Positions at or beyond L are blank.
  always_comb begin
    idx = '0;
    for (int k = 0; k < 6; k++) begin
      disp_d[k] = BLANK;
      idx = IDX_W'(offset_q) + IDX_W'(k);
      if (idx >= period) begin
        idx = idx - period;
      end
      if (state_q == ST_RUN) begin
        for (int j = 0; j < MSG_MAX; j++) begin
          if ((idx == IDX_W'(j)) && (idx < IDX_W'(len_q))) begin
            disp_d[k] = buf_q[j];
          end
        end
      end
    end
  end

  // Control and output registers; all return to idle/blank on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      offset_q   <= '0;
      tick_q     <= '0;
      wrap_q     <= 1'b0;
      ch_ready_q <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        disp_q[k] <= BLANK;
      end
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      offset_q   <= offset_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      ch_ready_q <= ch_ready_d;
      for (int k = 0; k < 6; k++) begin
        disp_q[k] <= disp_d[k];
      end
    end
  end

  // Message storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int j = 0; j < MSG_MAX; j++) begin
        if (len_q == LEN_W'(j)) begin
          buf_q[j] <= ch_seg_i;
        end
      end
    end
  end

  assign ch_ready_o        = ch_ready_q;
  assign msg_len_o         = len_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign wrap_o            = wrap_q;
  assign display0_output_o = disp_q[0];
  assign display1_output_o = disp_q[1];
  assign display2_output_o = disp_q[2];
  assign display3_output_o = disp_q[3];
  assign display4_output_o = disp_q[4];
  assign display5_output_o = disp_q[5];

endmodule

// File: tb/tb_ssd_scroll_controller.sv
// ---------------------------------------------------------------------------
// tb_ssd_scroll_controller
//
// Drives ssd_scroll_controller with directed and random message loads.
// A reference model tracks the message as a queue and the time spent
// scrolling as a cycle count; offsets, frames and wrap pulses are derived
// from that count arithmetically. Expected outputs for each clock edge are
// queued by the driver and compared by an independent monitor.
// ---------------------------------------------------------------------------
module tb_ssd_scroll_controller;

  localparam int MSG_MAX  = 16;
  localparam int TICK_DIV = 4;
  localparam int LEN_W    = $clog2(MSG_MAX + 1);
  localparam logic [0:6] BLANK = 7'b1111111;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

`ifdef SSD_SCROLL_STATIC_EN
  localparam bit STATIC_EN = 1'b1;
`else
  localparam bit STATIC_EN = 1'b0;
`endif

  typedef struct packed {
    logic             rdy;
    logic             busy;
    logic [LEN_W-1:0] len;
    logic             wrap;
    logic [5:0][0:6]  disp;
  } expect_t;

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             load_start = 1'b0;
  logic             ch_valid   = 1'b0;
  logic [0:6]       ch_seg     = 7'b1111111;
  logic             load_done  = 1'b0;
  logic             ch_ready;
  logic [LEN_W-1:0] msg_len;
  logic             busy;
  logic             wrap;
  logic [0:6]       d0, d1, d2, d3, d4, d5;
  logic [5:0][0:6]  act;

  int               vectors     = 0;
  int               miscompares = 0;
  expect_t          expQ[$];

  // Reference model state
  int               mState = M_IDLE;
  logic [0:6]       mMsg[$];
  int               mRun   = 0;

  ssd_scroll_controller #(
    .MSG_MAX (MSG_MAX),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .load_start_i     (load_start),
    .ch_valid_i       (ch_valid),
    .ch_seg_i         (ch_seg),
    .ch_ready_o       (ch_ready),
    .load_done_i      (load_done),
    .msg_len_o        (msg_len),
    .busy_o           (busy),
    .wrap_o           (wrap),
    .display0_output_o(d0),
    .display1_output_o(d1),
    .display2_output_o(d2),
    .display3_output_o(d3),
    .display4_output_o(d4),
    .display5_output_o(d5)
  );

  assign act[0] = d0;
  assign act[1] = d1;
  assign act[2] = d2;
  assign act[3] = d3;
  assign act[4] = d4;
  assign act[5] = d5;

  // 10-time-unit clock
  always #5 clk = ~clk;

  // Hard stop in case something hangs
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Whether the current message scrolls at all
  function automatic bit scrolls();
    return !(STATIC_EN && (mMsg.size() <= 6));
  endfunction

  // Frame the model would show for its present state
  function automatic logic [5:0][0:6] frameOf();
    logic [5:0][0:6] f;
    int p;
    int off;
    for (int k = 0; k < 6; k++) f[k] = BLANK;
    if (mState == M_RUN) begin
      p   = mMsg.size() + 6;
      off = scrolls() ? (mRun / TICK_DIV) % p : 0;
      for (int k = 0; k < 6; k++) begin
        int i;
        i = (off + k) % p;
        if (i < mMsg.size()) f[k] = mMsg[i];
      end
    end
    return f;
  endfunction

  // Generic comparison; every mismatch prints one line and counts
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
    end
  endtask

  // Compare all DUT outputs against one expected record
  task automatic checkOutput(input expect_t e);
    vectors++;
    cmp("ch_ready", 32'(ch_ready), 32'(e.rdy));
    cmp("busy", 32'(busy), 32'(e.busy));
    cmp("msg_len", 32'(msg_len), 32'(e.len));
    cmp("wrap", 32'(wrap), 32'(e.wrap));
    for (int k = 0; k < 6; k++) begin
      cmp($sformatf("display%0d", k), 32'(act[k]), 32'(e.disp[k]));
    end
  endtask

  // Monitor: after every rising edge, check the record queued for it
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic applyStimulus(input logic ls, input logic v, input logic [0:6] seg, input logic ld);
    expect_t e;
    bit      rdyNow;
    int      p;
    @(negedge clk);
    load_start = ls;
    ch_valid   = v;
    ch_seg     = seg;
    load_done  = ld;

    rdyNow = (mState == M_LOAD) && (mMsg.size() < MSG_MAX);
    // Displays are registered: after this edge they show the current frame
    e.disp = frameOf();

    case (mState)
      M_IDLE: begin
        if (ls) begin
          mState = M_LOAD;
          mMsg.delete();
        end
      end
      M_LOAD: begin
        if (ls) begin
          mMsg.delete();
        end else begin
          if (v && rdyNow) mMsg.push_back(seg);
          if (ld) begin
            if (mMsg.size() == 0) begin
              mState = M_IDLE;
            end else begin
              mState = M_RUN;
              mRun   = 0;
            end
          end
        end
      end
      default: begin
        if (ls) begin
          mState = M_LOAD;
          mMsg.delete();
        end else begin
          mRun++;
        end
      end
    endcase

    p      = mMsg.size() + 6;
    e.wrap = (mState == M_RUN) && scrolls() && (mRun > 0) && ((mRun % (TICK_DIV * p)) == 0);
    e.rdy  = (mState == M_LOAD) && (mMsg.size() < MSG_MAX);
    e.busy = (mState != M_IDLE);
    e.len  = LEN_W'(mMsg.size());
    expQ.push_back(e);
  endtask

  // Direct check of the values that must appear while reset is asserted
  task automatic checkResetValues();
    vectors++;
    cmp("rst_ch_ready", 32'(ch_ready), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_msg_len", 32'(msg_len), 32'd0);
    cmp("rst_wrap", 32'(wrap), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cmp($sformatf("rst_display%0d", k), 32'(act[k]), 32'(BLANK));
    end
  endtask

  // Assert reset between clock edges, check immediately, then release
  task automatic resetMidCycle();
    @(negedge clk);
    load_start = 1'b0;
    ch_valid   = 1'b0;
    load_done  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues();
    mState = M_IDLE;
    mMsg.delete();
    mRun = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run cycles in RUN with ignored noise on ch_valid and load_done
  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    logic [0:6] hello [5];
    int         n;
    hello[0] = 7'b1001000;
    hello[1] = 7'b0110000;
    hello[2] = 7'b1110001;
    hello[3] = 7'b1110001;
    hello[4] = 7'b0000001;

    // Power-on reset
    repeat (3) @(negedge clk);
    #1;
    checkResetValues();
    rst_n = 1'b1;

    // IDLE ignores glyphs and load_done
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 7'($urandom), 1'b1);

    // HELLO message, scrolled through more than two full periods
    applyStimulus(1'b1, 1'b0, BLANK, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, hello[i], 1'b0);
    applyStimulus(1'b0, 1'b0, BLANK, 1'b1);
    runCycles(110);

    // load_start and load_done together in RUN: load_start wins
    applyStimulus(1'b1, 1'b0, BLANK, 1'b1);
    applyStimulus(1'b0, 1'b0, BLANK, 1'b0);
    // Empty message returns to IDLE
    applyStimulus(1'b0, 1'b0, BLANK, 1'b1);
    applyStimulus(1'b0, 1'b0, BLANK, 1'b0);

    // Overfill: ch_valid held for 20 cycles, only MSG_MAX accepted
    applyStimulus(1'b1, 1'b0, BLANK, 1'b0);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b1, 7'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b0, BLANK, 1'b1);
    runCycles(100);

    // Glyph offered together with load_start is discarded
    applyStimulus(1'b1, 1'b0, BLANK, 1'b0);
    applyStimulus(1'b0, 1'b1, 7'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, 7'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b1, 7'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b1, 7'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b0, BLANK, 1'b1);
    runCycles(70);

    // Reset asserted mid-RUN
    resetMidCycle();

    // Random loads of varying length with occasional restarts
    for (int r = 0; r < 12; r++) begin
      applyStimulus(1'b1, 1'b0, BLANK, 1'b0);
      n = $urandom_range(0, MSG_MAX + 4);
      for (int c = 0; c < n; c++) begin
        applyStimulus(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                      7'($urandom), 1'b0);
      end
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 7'($urandom), 1'b1);
      n = $urandom_range(0, 150);
      for (int c = 0; c < n; c++) begin
        applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                      7'($urandom), 1'($urandom_range(0, 7) == 0));
      end
    end

    // Short message after the random phase, then a final reset
    applyStimulus(1'b1, 1'b0, BLANK, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, hello[i], 1'b0);
    applyStimulus(1'b0, 1'b0, BLANK, 1'b1);
    runCycles(40);
    resetMidCycle();

    // Every queued expectation must have been consumed by the monitor
    @(negedge clk);
    load_start = 1'b0;
    ch_valid   = 1'b0;
    load_done  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected records left, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
